pkt_rx_parser: RTL and testbench
================================

PKT_RX_PARSER -- requirements
Module: pkt_rx_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, giving the maximum idle gap between words of one frame.
REQ-002 SHALL have parameter BCAST_ID, default 16'hFFFF, the broadcast destination ID.
REQ-003 SHALL have ports: clk in 1, single clock, rising edge; rst in 1, reset, asynchronous, active-high.
REQ-004 SHALL have ports: rx_word in 16, incoming frame word; rx_valid in 1; rx_ready out 1 (word accepted when rx_valid && rx_ready).
REQ-005 SHALL have port myNodeID in 16, this node's ID for destination match.
REQ-006 SHALL have ports: fPacketType out 3; fSourceID, fDestinationID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH out 16 each (decoded fields).
REQ-007 SHALL have ports: pkt_valid out 1, frame ready; pkt_ack in 1, consumer taken frame; iAmDestination out 1; rx_err out 1, one-cycle error pulse; err_code out 2 (0 none, 1 timeout, 2 bad type, 3 checksum).

Function
REQ-008 Frame order SHALL be: W0 header ([15:13] packet type, [12:0] ignored), then W1 source ID, W2 destination ID, W3 source hops, W4 Q-value, W5 energy left, W6 hops from CH, W7 chosen CH, then (RX_CHECKSUM_EN only) W8 checksum.
REQ-009 FSM SHALL have states IDLE, RECV, CHECK, HOLD; reset state IDLE.
REQ-010 IDLE: rx_ready=1; an accepted word is W0 and the FSM moves to RECV with word counter=1.
REQ-011 RECV: rx_ready=1; each accepted word SHALL be stored in the field selected by the counter, and the counter SHALL increment; after the last word the FSM moves to CHECK.
REQ-012 CHECK (one cycle, rx_ready=0): a type of 3'b111 SHALL drop the frame with err_code=2; otherwise the FSM moves to HOLD.
REQ-013 HOLD: pkt_valid=1 and rx_ready=0, and outputs SHALL stay stable until pkt_ack; on pkt_ack the FSM moves to IDLE the next cycle.
REQ-014 pkt_ack SHALL be ignored outside HOLD.
REQ-015 iAmDestination SHALL be 1 in HOLD when fDestinationID==myNodeID or fDestinationID==BCAST_ID, else 0.
REQ-016 The gap counter SHALL clear on each accepted word in RECV and increment otherwise; on reaching TIMEOUT_CYCLES the frame is dropped, with rx_err pulse, err_code=1, and FSM to IDLE.
REQ-017 Dropped frames SHALL NOT assert pkt_valid, and field outputs SHALL keep their previous values.
REQ-018 rx_err SHALL be a single-cycle pulse; err_code SHALL hold its last value until the next error or reset.
REQ-019 Latency SHALL be: pkt_valid asserts 2 cycles after the last word is accepted.

Reset
REQ-020 Reset SHALL set all field outputs to 0, except fPacketType=3'b111, fSourceHops=16'hFFFF and fHopsFromCH=16'hFFFF; pkt_valid, iAmDestination and rx_err to 0; err_code to 0; rx_ready to 0 while rst is high.
REQ-021 Reset asserted mid-frame SHALL discard the partial frame immediately, with no error pulse.

Configuration
REQ-022 With macro PKT_RX_CHECKSUM_EN defined, frames SHALL be 9 words, with W8 equal to the XOR of W0..W7; on mismatch, CHECK SHALL drop the frame with err_code=3, and a bad-type error takes priority over checksum.
REQ-023 Without PKT_RX_CHECKSUM_EN, frames SHALL be 8 words and no checksum logic or state SHALL exist.

Structure
REQ-024 Shared package pkt_pkg SHALL hold WORD_WIDTH=16, the packet type enum (HEARTBEAT 3'b000, INVITE 3'b010, DATA 3'b101, INVALID 3'b111), the frame length constants and the err_code enum.
REQ-025 Sub-module pkt_rx_timeout (gap counter with clear/expire) SHALL be instantiated once; everything else is flat.

Verification
REQ-026 Heartbeat frame {16'h0000, src 0, dst FFFF, hops 3, Q 3555, E 7FFA, FFFF, 0} -> pkt_valid 2 cycles after the last word, fPacketType=000, iAmDestination=1 (broadcast).
REQ-027 DATA frame with dst=16'h000C, myNodeID=16'h000C, src 16'd35, chosenCH 16'h17 -> iAmDestination=1 and fields exact; hold pkt_ack low 5 cycles -> outputs stable and rx_ready=0 throughout.
REQ-028 Three words, then rx_valid low for 64 cycles -> rx_err pulse, err_code=1, no pkt_valid; the next full frame is parsed correctly.
REQ-029 Header type 3'b111 -> err_code=2, no pkt_valid; with PKT_RX_CHECKSUM_EN, W8 corrupted by 16'h0001 -> err_code=3.
REQ-030 rst asserted during W4 of a frame -> outputs return to reset values and no rx_err; a subsequent INVITE frame (type 010, src 23) is parsed correctly.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared definitions for the frame receive path: word width, packet types, error codes, frame length.
// Frame length grows by one checksum word when PKT_RX_CHECKSUM_EN is defined.
package pkt_pkg;
  localparam int WORD_WIDTH = 16;
  localparam int DATA_WORDS = 8;

`ifdef PKT_RX_CHECKSUM_EN
  localparam int FRAME_LEN = DATA_WORDS + 1;
`else
  localparam int FRAME_LEN = DATA_WORDS;
`endif

  typedef enum logic [2:0] {
    PT_HEARTBEAT = 3'b000,
    PT_INVITE    = 3'b010,
    PT_DATA      = 3'b101,
    PT_INVALID   = 3'b111
  } pkt_type_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_TIMEOUT  = 2'd1,
    ERR_BAD_TYPE = 2'd2,
    ERR_CHECKSUM = 2'd3
  } err_code_e;
endpackage

// File: rtl/pkt_rx_timeout.sv
// Inter-word gap counter: counts cycles while enabled and not cleared,
// and flags expiry on the TIMEOUT_CYCLES-th consecutive idle cycle.
module pkt_rx_timeout #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  assign expire = en && !clr && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || clr || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/pkt_rx_parser.sv
// Word-serial frame receiver: collects a frame into shadow registers, validates it, then
// presents decoded fields until acknowledged. Optional checksum word: PKT_RX_CHECKSUM_EN.
import pkt_pkg::*;

module pkt_rx_parser #(
  parameter int                    TIMEOUT_CYCLES = 64,
  parameter logic [WORD_WIDTH-1:0] BCAST_ID       = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] rx_word,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  output logic [2:0]            fPacketType,
  output logic [WORD_WIDTH-1:0] fSourceID,
  output logic [WORD_WIDTH-1:0] fDestinationID,
  output logic [WORD_WIDTH-1:0] fSourceHops,
  output logic [WORD_WIDTH-1:0] fQValue,
  output logic [WORD_WIDTH-1:0] fEnergyLeft,
  output logic [WORD_WIDTH-1:0] fHopsFromCH,
  output logic [WORD_WIDTH-1:0] fChosenCH,
  output logic                  pkt_valid,
  input  logic                  pkt_ack,
  output logic                  iAmDestination,
  output logic                  rx_err,
  output logic [1:0]            err_code
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [3:0]            slot;
  logic                  accept;
  logic                  gap_en;
  logic                  expire;
  logic [2:0]            s_type;
  logic [WORD_WIDTH-1:0] s_src, s_dst, s_hops, s_q, s_energy, s_hch, s_ch;

  assign rx_ready       = !rst && (state == S_IDLE || state == S_RECV);
  assign accept         = rx_valid && rx_ready;
  assign slot           = (state == S_IDLE) ? 4'd0 : cnt;
  assign gap_en         = (state == S_RECV);
  assign pkt_valid      = (state == S_HOLD);
  assign iAmDestination = pkt_valid && (fDestinationID == myNodeID || fDestinationID == BCAST_ID);

  pkt_rx_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .en     (gap_en),
    .clr    (accept),
    .expire (expire)
  );

  // Shadow registers keep the visible fields untouched until a frame is validated.
  always_ff @(posedge clk) begin
    if (accept) begin
      case (slot)
        4'd0:    s_type   <= rx_word[15:13];
        4'd1:    s_src    <= rx_word;
        4'd2:    s_dst    <= rx_word;
        4'd3:    s_hops   <= rx_word;
        4'd4:    s_q      <= rx_word;
        4'd5:    s_energy <= rx_word;
        4'd6:    s_hch    <= rx_word;
        4'd7:    s_ch     <= rx_word;
        default: ;
      endcase
    end
  end

`ifdef PKT_RX_CHECKSUM_EN
  // Running XOR over all words; a good frame folds to zero once W8 is included.
  logic [WORD_WIDTH-1:0] csum;

  always_ff @(posedge clk) begin
    if (accept) begin
      csum <= (state == S_IDLE) ? rx_word : (csum ^ rx_word);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= 4'd0;
      rx_err         <= 1'b0;
      err_code       <= ERR_NONE;
      fPacketType    <= PT_INVALID;
      fSourceID      <= '0;
      fDestinationID <= '0;
      fSourceHops    <= 16'hFFFF;
      fQValue        <= '0;
      fEnergyLeft    <= '0;
      fHopsFromCH    <= 16'hFFFF;
      fChosenCH      <= '0;
    end else begin
      rx_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_RECV;
            cnt   <= 4'd1;
          end
        end
        S_RECV: begin
          if (expire) begin
            state    <= S_IDLE;
            rx_err   <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end else if (accept) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'(FRAME_LEN - 1)) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (s_type == PT_INVALID) begin
            state    <= S_IDLE;
            rx_err   <= 1'b1;
            err_code <= ERR_BAD_TYPE;
`ifdef PKT_RX_CHECKSUM_EN
          end else if (csum != '0) begin
            state    <= S_IDLE;
            rx_err   <= 1'b1;
            err_code <= ERR_CHECKSUM;
`endif
          end else begin
            state          <= S_HOLD;
            fPacketType    <= s_type;
            fSourceID      <= s_src;
            fDestinationID <= s_dst;
            fSourceHops    <= s_hops;
            fQValue        <= s_q;
            fEnergyLeft    <= s_energy;
            fHopsFromCH    <= s_hch;
            fChosenCH      <= s_ch;
          end
        end
        default: begin
          if (pkt_ack) state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pkt_rx_parser.sv
// Self-checking bench for pkt_rx_parser: frame-level reference model compared every cycle,
// plus directed frames with literal expectations. Honours PKT_RX_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_pkt_rx_parser;
`ifdef PKT_RX_CHECKSUM_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rx_word = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [15:0] myNodeID = 16'h000C;
  logic [2:0]  fPacketType;
  logic [15:0] fSourceID, fDestinationID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH;
  logic        pkt_valid;
  logic        pkt_ack = 1'b0;
  logic        iAmDestination;
  logic        rx_err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_errors = 0;

  pkt_rx_parser #(.TIMEOUT_CYCLES(TMO), .BCAST_ID(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .rx_word(rx_word), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .myNodeID(myNodeID), .fPacketType(fPacketType), .fSourceID(fSourceID),
    .fDestinationID(fDestinationID), .fSourceHops(fSourceHops), .fQValue(fQValue),
    .fEnergyLeft(fEnergyLeft), .fHopsFromCH(fHopsFromCH), .fChosenCH(fChosenCH),
    .pkt_valid(pkt_valid), .pkt_ack(pkt_ack), .iAmDestination(iAmDestination),
    .rx_err(rx_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Frame-level model: phase 0 gathering words, 1 frame complete awaiting verdict, 2 presented.
  logic [15:0] mq[$];
  logic [15:0] ef[8] = '{16'hE000, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0, 16'hFFFF, 16'h0};
  int          gap = 0;
  int          phase = 0;
  logic        e_err = 1'b0;
  logic [1:0]  e_code = 2'd0;

  always @(posedge clk or posedge rst) begin
    logic [15:0] x;
    logic [15:0] hdr;
    if (rst) begin
      mq.delete();
      gap = 0; phase = 0; e_err = 1'b0; e_code = 2'd0;
      ef = '{16'hE000, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0, 16'hFFFF, 16'h0};
    end else begin
      e_err = 1'b0;
      if (phase == 0) begin
        if (rx_valid) begin
          mq.push_back(rx_word);
          gap = 0;
          if (mq.size() == FL) phase = 1;
        end else if (mq.size() > 0) begin
          gap++;
          if (gap == TMO) begin
            mq.delete(); e_err = 1'b1; e_code = 2'd1;
          end
        end
      end else if (phase == 1) begin
        x = '0;
        foreach (mq[i]) x ^= mq[i];
        hdr = mq[0];
        if (hdr[15:13] == 3'b111) begin
          e_err = 1'b1; e_code = 2'd2; phase = 0; mq.delete();
`ifdef PKT_RX_CHECKSUM_EN
        end else if (x != 16'h0) begin
          e_err = 1'b1; e_code = 2'd3; phase = 0; mq.delete();
`endif
        end else begin
          for (int i = 0; i < 8; i++) ef[i] = mq[i];
          phase = 2;
        end
      end else if (pkt_ack) begin
        phase = 0; mq.delete();
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] h;
    h = ef[0];
    chk("rx_ready", rx_ready, (phase == 0) && !rst);
    chk("pkt_valid", pkt_valid, phase == 2);
    chk("iAmDestination", iAmDestination, (phase == 2) && (ef[2] == myNodeID || ef[2] == 16'hFFFF));
    chk("rx_err", rx_err, e_err);
    chk("err_code", err_code, e_code);
    chk("fPacketType", fPacketType, h[15:13]);
    chk("fSourceID", fSourceID, ef[1]);
    chk("fDestinationID", fDestinationID, ef[2]);
    chk("fSourceHops", fSourceHops, ef[3]);
    chk("fQValue", fQValue, ef[4]);
    chk("fEnergyLeft", fEnergyLeft, ef[5]);
    chk("fHopsFromCH", fHopsFromCH, ef[6]);
    chk("fChosenCH", fChosenCH, ef[7]);
  end

  logic [15:0] fr[9];

  task automatic build(input logic [15:0] h, s, d, hp, q, e, hc, c);
    fr[0] = h; fr[1] = s; fr[2] = d; fr[3] = hp; fr[4] = q; fr[5] = e; fr[6] = hc; fr[7] = c;
    fr[8] = h ^ s ^ d ^ hp ^ q ^ e ^ hc ^ c;
  endtask

  task automatic put_word(input logic [15:0] w);
    int b = 0;
    while (!rx_ready && b < 50) begin
      @(posedge clk); #1; b++;
    end
    if (b >= 50) chk("ready_wait_expired", 32'd1, 32'd0);
    rx_word = w; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) put_word(fr[i]);
  endtask

  task automatic ack();
    pkt_ack = 1'b1;
    @(posedge clk); #1;
    pkt_ack = 1'b0;
  endtask

  task automatic wait_err(input int limit, output int found);
    found = 0;
    for (int c = 1; c <= limit && found == 0; c++) begin
      @(posedge clk); #1;
      if (rx_err) found = c;
    end
  endtask

  initial begin
    int f;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", rx_ready, 1'b0);
    chk("rst_type", fPacketType, 3'b111);
    chk("rst_hops", fSourceHops, 16'hFFFF);
    chk("rst_hch", fHopsFromCH, 16'hFFFF);
    chk("rst_code", err_code, 2'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    ack();  // must be ignored while idle

    // Heartbeat to broadcast: pkt_valid two cycles after last word
    build(16'h0000, 16'h0000, 16'hFFFF, 16'h0003, 16'h3555, 16'h7FFA, 16'hFFFF, 16'h0000);
    send(FL);
    chk("hb_lat1", pkt_valid, 1'b0);
    @(posedge clk); #1;
    chk("hb_lat2", pkt_valid, 1'b1);
    chk("hb_type", fPacketType, 3'b000);
    chk("hb_dest", iAmDestination, 1'b1);
    chk("hb_q", fQValue, 16'h3555);
    ack();

    // Unicast DATA frame to this node, held for five cycles without ack
    build(16'hA000, 16'd35, 16'h000C, 16'h0002, 16'h1234, 16'h5000, 16'h0001, 16'h0017);
    send(FL);
    @(posedge clk); #1;
    chk("data_type", fPacketType, 3'b101);
    chk("data_dest", iAmDestination, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_ready", rx_ready, 1'b0);
      chk("hold_valid", pkt_valid, 1'b1);
      chk("hold_src", fSourceID, 16'd35);
      chk("hold_ch", fChosenCH, 16'h0017);
    end
    ack();

    // Timeout after three words
    build(16'h4000, 16'h0077, 16'h000C, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5);
    send(3);
    wait_err(80, f);
    chk("tmo_cycle", f, 64);
    chk("tmo_code", err_code, 2'd1);
    chk("tmo_valid", pkt_valid, 1'b0);
    chk("tmo_keep_src", fSourceID, 16'd35);
    @(posedge clk); #1;
    chk("tmo_pulse", rx_err, 1'b0);

    // Frame for another node after the timeout
    build(16'hA000, 16'h0101, 16'h0055, 16'h0004, 16'h0AAA, 16'h0BBB, 16'h0002, 16'h0033);
    send(FL);
    @(posedge clk); #1;
    chk("other_valid", pkt_valid, 1'b1);
    chk("other_dest", iAmDestination, 1'b0);
    chk("other_dst", fDestinationID, 16'h0055);
    chk("other_code", err_code, 2'd1);
    ack();

    // Invalid header type
    build(16'hE000, 16'h0009, 16'h000C, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5);
    send(FL);
    wait_err(5, f);
    chk("bad_cycle", f, 1);
    chk("bad_code", err_code, 2'd2);
    chk("bad_valid", pkt_valid, 1'b0);
    chk("bad_keep_type", fPacketType, 3'b101);

`ifdef PKT_RX_CHECKSUM_EN
    build(16'hA000, 16'h0042, 16'h000C, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5);
    fr[8] = fr[8] ^ 16'h0001;
    send(FL);
    wait_err(5, f);
    chk("csum_cycle", f, 1);
    chk("csum_code", err_code, 2'd3);
    chk("csum_keep_src", fSourceID, 16'h0101);
`endif

    // Reset arriving while W4 is on the bus
    build(16'h2000, 16'h0066, 16'h000C, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5);
    send(4);
    rx_word = fr[4]; rx_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_type", fPacketType, 3'b111);
    chk("mid_rst_src", fSourceID, 16'h0);
    chk("mid_rst_code", err_code, 2'd0);
    chk("mid_rst_err", rx_err, 1'b0);
    chk("mid_rst_ready", rx_ready, 1'b0);
    rx_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // INVITE after reset
    build(16'h4000, 16'd23, 16'hFFFF, 16'h0001, 16'h0100, 16'h0200, 16'h0003, 16'h0023);
    send(FL);
    @(posedge clk); #1;
    chk("inv_valid", pkt_valid, 1'b1);
    chk("inv_type", fPacketType, 3'b010);
    chk("inv_src", fSourceID, 16'd23);
    ack();
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
